// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - load handshake bundle for seg_scan_ctrl
interface seg_scan_ctrl_if;
  logic       ld_valid;
  logic       ld_sel;
  logic [5:0] ld_data;
  logic       ld_ready;

  modport master (
    output ld_valid,
    output ld_sel,
    output ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_sel,
    input  ld_data,
    output ld_ready
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller with frame-synchronous value commit
// Optional SEG_LEAD_ZERO_BLANK_EN: blank a tens digit of zero instead of showing glyph 0.
module seg_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  ld,
  output logic [3:0]      an,
  output logic [7:0]      seg
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef SEG_LEAD_ZERO_BLANK_EN
  localparam bit LEAD_BLANK = 1'b1;
`else
  localparam bit LEAD_BLANK = 1'b0;
`endif

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      idx, idx_nxt;
  logic [5:0]      shadow0, shadow1;
  logic [5:0]      active0, active1;
  logic [5:0]      active0_nxt, active1_nxt;
  logic [1:0]      pending, pending_nxt;
  logic [3:0]      an_nxt;
  logic [7:0]      seg_nxt;
  logic            wrap;
  logic            frame_end;
  logic            accept;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1111110;
      4'd1:    g = 7'b0110000;
      4'd2:    g = 7'b1101101;
      4'd3:    g = 7'b1111001;
      4'd4:    g = 7'b0110011;
      4'd5:    g = 7'b1011011;
      4'd6:    g = 7'b1011111;
      4'd7:    g = 7'b1110000;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1110011;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // Even idx is a units digit, odd idx a tens digit; idx[1] picks the slot.
  function automatic logic [7:0] seg_code(input logic [1:0] i,
                                          input logic [5:0] v0,
                                          input logic [5:0] v1);
    logic [5:0] v;
    logic [4:0] mag;
    logic [1:0] tens;
    logic [3:0] units;
    logic [3:0] digit;
    logic       is_units;
    logic       dp;
    logic [7:0] code;
    v   = i[1] ? v1 : v0;
    mag = v[4:0];
    if (mag >= 5'd30)      tens = 2'd3;
    else if (mag >= 5'd20) tens = 2'd2;
    else if (mag >= 5'd10) tens = 2'd1;
    else                   tens = 2'd0;
    units    = 4'(mag - 5'(tens) * 5'd10);
    is_units = ~i[0];
    digit    = is_units ? units : {2'b00, tens};
    // Negative zero shows no minus sign.
    dp       = is_units & v[5] & (mag != 5'd0);
    code     = ~{glyph(digit), dp};
    if (LEAD_BLANK && !is_units && (tens == 2'd0))
      code = 8'hFF;
    return code;
  endfunction

  assign ld.ld_ready = ~pending[ld.ld_sel];
  assign accept      = ld.ld_valid & ld.ld_ready;
  assign wrap        = (cnt == CW'(DIV - 1));
  assign frame_end   = wrap && (idx == 2'd3);

  always_comb begin
    cnt_nxt   = wrap ? '0 : cnt + CW'(1);
    idx_nxt   = wrap ? idx + 2'd1 : idx;
    state_nxt = state;
    if (cnt == CW'(BLANK - 1))
      state_nxt = ST_SHOW;
    else if (wrap)
      state_nxt = ST_BLANK;
  end

  // Commit happens on the frame's last cycle; a load accepted then only arms pending.
  always_comb begin
    active0_nxt = active0;
    active1_nxt = active1;
    pending_nxt = pending;
    if (frame_end) begin
      if (pending[0]) active0_nxt = shadow0;
      if (pending[1]) active1_nxt = shadow1;
      pending_nxt = 2'b00;
    end
    if (accept) begin
      if (ld.ld_sel) pending_nxt[1] = 1'b1;
      else           pending_nxt[0] = 1'b1;
    end
  end

  // Outputs are registered from next-state so they line up with cnt.
  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = seg_code(idx_nxt, active0_nxt, active1_nxt);
    if (state_nxt == ST_SHOW)
      an_nxt = ~(4'b0001 << idx_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 2'd0;
      state   <= ST_BLANK;
      an      <= 4'b1111;
      seg     <= 8'hFF;
      shadow0 <= 6'b000000;
      shadow1 <= 6'b000000;
      active0 <= 6'b000000;
      active1 <= 6'b000000;
      pending <= 2'b00;
    end else begin
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      state   <= state_nxt;
      an      <= an_nxt;
      seg     <= seg_nxt;
      active0 <= active0_nxt;
      active1 <= active1_nxt;
      pending <= pending_nxt;
      if (accept && !ld.ld_sel) shadow0 <= ld.ld_data;
      if (accept &&  ld.ld_sel) shadow1 <= ld.ld_data;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl (DIV=8, BLANK=2)
module tb_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

`ifdef SEG_LEAD_ZERO_BLANK_EN
  localparam logic [7:0] TZ = 8'hFF;
`else
  localparam logic [7:0] TZ = 8'h03;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] an;
  logic [7:0] seg;
  int         n_checks = 0;
  int         n_fail   = 0;

  seg_scan_ctrl_if ldif ();

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .ld  (ldif.slave),
    .an  (an),
    .seg (seg)
  );

  always #5 clk = ~clk;

  task automatic drive_load(input logic sel, input logic [5:0] data);
    ldif.ld_valid = 1'b1;
    ldif.ld_sel   = sel;
    ldif.ld_data  = data;
    #1;
  endtask

  // Called at the sampling point of cnt 0 / idx 0; returns at the next frame start.
  task automatic check_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input bit skip0);
    logic [7:0] ex [4];
    logic [3:0] ea;
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < DIV; k++) begin
        ea = (k < BLANK) ? 4'b1111 : ~(4'b0001 << p);
        n_checks++;
        if (an !== ea) begin
          n_fail++;
          $display("FAIL %s an idx%0d cnt%0d: got %b expected %b", name, p, k, an, ea);
        end
        if (!(skip0 && p == 0 && k == 0)) begin
          n_checks++;
          if (seg !== ex[p]) begin
            n_fail++;
            $display("FAIL %s seg idx%0d cnt%0d: got %h expected %h", name, p, k, seg, ex[p]);
          end
        end
        @(negedge clk);
        #1;
        ldif.ld_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ldif.ld_valid = 1'b0;
    ldif.ld_sel   = 1'b0;
    ldif.ld_data  = 6'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", an); end
    n_checks++;
    if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h expected ff", seg); end
    n_checks++;
    if (ldif.ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready0: got %b expected 1", ldif.ld_ready); end
    ldif.ld_sel = 1'b1;
    #1;
    n_checks++;
    if (ldif.ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready1: got %b expected 1", ldif.ld_ready); end
    rst = 1'b0;
    check_frame("idle", 8'h03, TZ, 8'h03, TZ, 1'b1);
  endtask

  task automatic test_load_positive;
    drive_load(1'b0, 6'b010111);
    n_checks++;
    if (ldif.ld_ready !== 1'b1) begin n_fail++; $display("FAIL pos_ready: got %b expected 1", ldif.ld_ready); end
    check_frame("pos_pre", 8'h03, TZ, 8'h03, TZ, 1'b0);
    check_frame("pos_23", 8'h0D, 8'h25, 8'h03, TZ, 1'b0);
  endtask

  task automatic test_load_negative;
    drive_load(1'b1, 6'b100111);
    check_frame("neg_pre", 8'h0D, 8'h25, 8'h03, TZ, 1'b0);
    check_frame("neg_7", 8'h0D, 8'h25, 8'h1E, TZ, 1'b0);
  endtask

  task automatic test_extremes;
    drive_load(1'b0, 6'b011111);
    check_frame("max_pre", 8'h0D, 8'h25, 8'h1E, TZ, 1'b0);
    check_frame("max_31", 8'h9F, 8'h0D, 8'h1E, TZ, 1'b0);
    drive_load(1'b0, 6'b100000);
    check_frame("nz_pre", 8'h9F, 8'h0D, 8'h1E, TZ, 1'b0);
    check_frame("neg_zero", 8'h03, TZ, 8'h1E, TZ, 1'b0);
  endtask

  task automatic test_double_load;
    drive_load(1'b1, 6'd5);
    n_checks++;
    if (ldif.ld_ready !== 1'b1) begin n_fail++; $display("FAIL dbl_first_ready: got %b expected 1", ldif.ld_ready); end
    @(negedge clk);
    drive_load(1'b1, 6'd9);
    n_checks++;
    if (ldif.ld_ready !== 1'b0) begin n_fail++; $display("FAIL dbl_second_ready: got %b expected 0", ldif.ld_ready); end
    @(negedge clk);
    drive_load(1'b0, 6'd12);
    n_checks++;
    if (ldif.ld_ready !== 1'b1) begin n_fail++; $display("FAIL dbl_other_slot_ready: got %b expected 1", ldif.ld_ready); end
    @(negedge clk);
    ldif.ld_valid = 1'b0;
    repeat (28) @(negedge clk);
    ldif.ld_sel = 1'b1;
    #1;
    n_checks++;
    if (ldif.ld_ready !== 1'b0) begin n_fail++; $display("FAIL dbl_ready1_before_commit: got %b expected 0", ldif.ld_ready); end
    ldif.ld_sel = 1'b0;
    #1;
    n_checks++;
    if (ldif.ld_ready !== 1'b0) begin n_fail++; $display("FAIL dbl_ready0_before_commit: got %b expected 0", ldif.ld_ready); end
    @(negedge clk);
    #1;
    n_checks++;
    if (ldif.ld_ready !== 1'b1) begin n_fail++; $display("FAIL dbl_ready0_after_commit: got %b expected 1", ldif.ld_ready); end
    ldif.ld_sel = 1'b1;
    #1;
    n_checks++;
    if (ldif.ld_ready !== 1'b1) begin n_fail++; $display("FAIL dbl_ready1_after_commit: got %b expected 1", ldif.ld_ready); end
    check_frame("dbl_show", 8'h25, 8'h9F, 8'h49, TZ, 1'b0);
  endtask

  task automatic test_commit_boundary;
    repeat (31) @(negedge clk);
    drive_load(1'b1, 6'd3);
    n_checks++;
    if (ldif.ld_ready !== 1'b1) begin n_fail++; $display("FAIL edge_ready: got %b expected 1", ldif.ld_ready); end
    @(negedge clk);
    ldif.ld_valid = 1'b0;
    #1;
    n_checks++;
    if (ldif.ld_ready !== 1'b0) begin n_fail++; $display("FAIL edge_pending: got %b expected 0", ldif.ld_ready); end
    check_frame("edge_deferred", 8'h25, 8'h9F, 8'h49, TZ, 1'b0);
    check_frame("edge_commit", 8'h25, 8'h9F, 8'h0D, TZ, 1'b0);
  endtask

  task automatic test_reset_mid;
    repeat (11) @(negedge clk);
    n_checks++;
    if (an !== 4'b1101) begin n_fail++; $display("FAIL mid_pre_an: got %b expected 1101", an); end
    n_checks++;
    if (seg !== 8'h9F) begin n_fail++; $display("FAIL mid_pre_seg: got %h expected 9f", seg); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL mid_rst_an: got %b expected 1111", an); end
    n_checks++;
    if (seg !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_seg: got %h expected ff", seg); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_frame("mid_restart", 8'h03, TZ, 8'h03, TZ, 1'b1);
  endtask

  initial begin
    test_reset;
    test_load_positive;
    test_load_negative;
    test_extremes;
    test_double_load;
    test_commit_boundary;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
